prog_loader: RTL and testbench

Boot-time instruction loader for `PipeSystem`. It receives a framed little-endian byte stream over a valid/ready handshake and assembles it into 32-bit words. Each word is written sequentially into the instruction memory write port, and the frame's XOR checksum is verified. `cpuReset` holds `PipeCPU` in reset until a complete, valid program has landed. The loader replaces hierarchical `.mem` preloading, so the same arithmetic and logic programs can be delivered over a link on hardware.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader.sv | 139 +++++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction loader.
package prog_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0]        LAST_BYTE = 2'd3;
    localparam logic [BYTE_W-1:0] CSUM_INIT = '0;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Receives a framed little-endian byte stream, writes 32-bit words to instruction
// memory and releases cpuReset once the frame checksum has matched.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    input  logic [BYTE_W-1:0]     inData,
    output logic                  inReady,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [WORD_W-1:0]     memWriteData,
    output logic                  cpuReset,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [32:0]           CAPACITY = 33'd1 << ADDR_WIDTH;

    loader_state_t         state;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_sr;
    logic [15:0]           len;
    logic [15:0]           word_idx;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BYTE_W-1:0]     csum;

    logic                  accept;
    logic [15:0]           len_full;
    logic                  len_too_big;
    logic                  last_word;

    always_comb begin
        accept      = inValid && inReady;
        len_full    = {inData, len[7:0]};
        len_too_big = {17'd0, len_full} > CAPACITY;
        last_word   = (word_idx == (len - 16'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_LEN0;
            inReady      <= 1'b1;
            memWrite     <= 1'b0;
            memAddr      <= BASE;
            memWriteData <= '0;
            cpuReset     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            byte_cnt     <= '0;
            word_sr      <= '0;
            len          <= '0;
            word_idx     <= '0;
            wr_addr      <= BASE;
            csum         <= CSUM_INIT;
        end else begin
            memWrite <= 1'b0;
            case (state)
                ST_LEN0: begin
                    if (accept) begin
                        len[7:0] <= inData;
                        csum     <= csum ^ inData;
                        state    <= ST_LEN1;
                    end
                end

                ST_LEN1: begin
                    if (accept) begin
                        len  <= len_full;
                        csum <= csum ^ inData;
                        if (len_too_big) begin
                            state   <= ST_ERR;
                            inReady <= 1'b0;
                            error   <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ inData;
                        byte_cnt <= byte_cnt + 2'd1;
                        // The 4th byte bypasses the shift register straight into the write data.
                        if (byte_cnt == LAST_BYTE) begin
                            memWrite     <= 1'b1;
                            memAddr      <= wr_addr;
                            memWriteData <= {inData, word_sr};
                            wr_addr      <= wr_addr + 1'b1;
                            word_idx     <= word_idx + 16'd1;
                            if (last_word) begin
                                state <= ST_CSUM;
                            end
                        end else begin
                            word_sr <= {inData, word_sr[23:8]};
                        end
                    end
                end

                ST_CSUM: begin
                    if (accept) begin
                        inReady <= 1'b0;
                        if (inData == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpuReset <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    inReady <= 1'b0;
                end

                ST_ERR: begin
                    inReady <= 1'b0;
                end

                default: begin
                    state   <= ST_ERR;
                    inReady <= 1'b0;
                    error   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed checks of prog_loader: default instance plus a 4-word-capacity instance.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        va = 1'b0;
    logic        vb = 1'b0;
    logic [7:0]  din = 8'h00;

    logic        rdy_a, wr_a, cpu_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic        rdy_b, wr_b, cpu_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [9:0]  qa_addr[$];
    logic [31:0] qa_data[$];
    logic [1:0]  qb_addr[$];
    logic [31:0] qb_data[$];
    logic [7:0]  bq[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(rst_a), .inValid(va), .inData(din), .inReady(rdy_a),
        .memWrite(wr_a), .memAddr(addr_a), .memWriteData(data_a),
        .cpuReset(cpu_a), .done(done_a), .error(err_a)
    );

    prog_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .reset(rst_b), .inValid(vb), .inData(din), .inReady(rdy_b),
        .memWrite(wr_b), .memAddr(addr_b), .memWriteData(data_b),
        .cpuReset(cpu_b), .done(done_b), .error(err_b)
    );

    always @(negedge clk) begin
        if (wr_a) begin
            qa_addr.push_back(addr_a);
            qa_data.push_back(data_a);
        end
        if (wr_b) begin
            qb_addr.push_back(addr_b);
            qb_data.push_back(data_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input bit sel);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        qa_addr.delete(); qa_data.delete();
        qb_addr.delete(); qb_data.delete();
    endtask

    // Returns #1 after the handshake edge, so registered responses are visible.
    task automatic send_byte(input bit sel, input logic [7:0] b);
        int unsigned n;
        n = 0;
        din = b;
        if (sel) vb = 1'b1; else va = 1'b1;
        while (((sel ? rdy_b : rdy_a) == 1'b0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            check("handshake_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic send_q(input bit sel, input bit gap);
        foreach (bq[i]) begin
            send_byte(sel, bq[i]);
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        // reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_inReady", {31'd0, rdy_a}, 32'd1);
        check("rst_memWrite", {31'd0, wr_a}, 32'd0);
        check("rst_memAddr", {22'd0, addr_a}, 32'd0);
        check("rst_memWriteData", data_a, 32'd0);
        check("rst_cpuReset", {31'd0, cpu_a}, 32'd1);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_error", {31'd0, err_a}, 32'd0);
        do_reset(1'b0);

        // basic load: 01 00 44 33 22 11 45
        bq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22};
        send_q(1'b0, 1'b0);
        check("basic_no_early_write", {31'd0, wr_a}, 32'd0);
        send_byte(1'b0, 8'h11);
        check("basic_wr_pulse", {31'd0, wr_a}, 32'd1);
        check("basic_wr_addr", {22'd0, addr_a}, 32'd0);
        check("basic_wr_data", data_a, 32'h11223344);
        check("basic_done_before_csum", {31'd0, done_a}, 32'd0);
        check("basic_cpu_before_csum", {31'd0, cpu_a}, 32'd1);
        send_byte(1'b0, 8'h45);
        check("basic_wr_one_cycle", {31'd0, wr_a}, 32'd0);
        check("basic_done", {31'd0, done_a}, 32'd1);
        check("basic_cpuReset", {31'd0, cpu_a}, 32'd0);
        check("basic_inReady", {31'd0, rdy_a}, 32'd0);
        check("basic_error", {31'd0, err_a}, 32'd0);
        check("basic_wr_count", qa_addr.size(), 32'd1);

        // 3-word program, back to back
        do_reset(1'b0);
        bq = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h78, 8'h56, 8'h34, 8'h12, 8'h3A};
        send_q(1'b0, 1'b0);
        check("prog_wr_count", qa_addr.size(), 32'd3);
        if (qa_addr.size() == 3) begin
            check("prog_addr0", {22'd0, qa_addr[0]}, 32'd0);
            check("prog_data0", qa_data[0], 32'h00000013);
            check("prog_addr1", {22'd0, qa_addr[1]}, 32'd1);
            check("prog_data1", qa_data[1], 32'hDEADBEEF);
            check("prog_addr2", {22'd0, qa_addr[2]}, 32'd2);
            check("prog_data2", qa_data[2], 32'h12345678);
        end
        check("prog_done", {31'd0, done_a}, 32'd1);
        check("prog_cpuReset", {31'd0, cpu_a}, 32'd0);

        // zero length, then a second frame is refused
        do_reset(1'b0);
        bq = '{8'h00, 8'h00, 8'h00};
        send_q(1'b0, 1'b0);
        check("zero_done", {31'd0, done_a}, 32'd1);
        check("zero_inReady", {31'd0, rdy_a}, 32'd0);
        din = 8'h01;
        va = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        va = 1'b0;
        check("zero_no_write", qa_addr.size(), 32'd0);
        check("zero_still_done", {31'd0, done_a}, 32'd1);
        check("zero_no_error", {31'd0, err_a}, 32'd0);

        // bad checksum
        do_reset(1'b0);
        bq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h46};
        send_q(1'b0, 1'b0);
        check("badcs_wr_count", qa_addr.size(), 32'd1);
        if (qa_data.size() == 1) check("badcs_wr_data", qa_data[0], 32'h11223344);
        check("badcs_error", {31'd0, err_a}, 32'd1);
        check("badcs_cpuReset", {31'd0, cpu_a}, 32'd1);
        check("badcs_done", {31'd0, done_a}, 32'd0);
        check("badcs_inReady", {31'd0, rdy_a}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("badcs_error_sticky", {31'd0, err_a}, 32'd1);

        // 2-word frame with inValid gaps on alternate cycles
        do_reset(1'b0);
        bq = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8A};
        send_q(1'b0, 1'b1);
        check("gap_wr_count", qa_addr.size(), 32'd2);
        if (qa_addr.size() == 2) begin
            check("gap_addr0", {22'd0, qa_addr[0]}, 32'd0);
            check("gap_data0", qa_data[0], 32'h11223344);
            check("gap_addr1", {22'd0, qa_addr[1]}, 32'd1);
            check("gap_data1", qa_data[1], 32'h55667788);
        end
        check("gap_done", {31'd0, done_a}, 32'd1);

        // reset mid-load wins over a simultaneous handshake
        do_reset(1'b0);
        bq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22};
        send_q(1'b0, 1'b0);
        din = 8'h11;
        va = 1'b1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        va = 1'b0;
        rst_a = 1'b0;
        @(posedge clk); #1;
        check("midrst_no_write", qa_addr.size(), 32'd0);
        check("midrst_inReady", {31'd0, rdy_a}, 32'd1);
        check("midrst_cpuReset", {31'd0, cpu_a}, 32'd1);
        bq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        send_q(1'b0, 1'b0);
        check("midrst_wr_count", qa_addr.size(), 32'd1);
        if (qa_addr.size() == 1) begin
            check("midrst_addr", {22'd0, qa_addr[0]}, 32'd0);
            check("midrst_data", qa_data[0], 32'hDDCCBBAA);
        end
        check("midrst_done", {31'd0, done_a}, 32'd1);

        // small instance: exactly full capacity, no wrap
        do_reset(1'b1);
        bq = '{8'h04, 8'h00,
               8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        send_q(1'b1, 1'b0);
        check("full_wr_count", qb_addr.size(), 32'd4);
        if (qb_addr.size() == 4) begin
            check("full_addr3", {30'd0, qb_addr[3]}, 32'd3);
            check("full_data3", qb_data[3], 32'h00000004);
            check("full_addr0", {30'd0, qb_addr[0]}, 32'd0);
        end
        check("full_done", {31'd0, done_b}, 32'd1);
        check("full_error", {31'd0, err_b}, 32'd0);

        // small instance: oversize length rejected right after LEN_HI
        do_reset(1'b1);
        send_byte(1'b1, 8'h05);
        check("over_after_lo", {31'd0, err_b}, 32'd0);
        send_byte(1'b1, 8'h00);
        check("over_error", {31'd0, err_b}, 32'd1);
        check("over_inReady", {31'd0, rdy_b}, 32'd0);
        check("over_cpuReset", {31'd0, cpu_b}, 32'd1);
        check("over_done", {31'd0, done_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
